key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_pkg.sv | 30 +++
 rtl/key_event_decoder_if.sv | 22 ++
 rtl/key_timer.sv | 26 ++
 rtl/key_event_decoder.sv | 149 ++++++++++++++
 tb/tb_key_event_decoder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key event decoder: one-hot state codes,
// 26-bit cycle counter type and default timing constants for a 50 MHz clock.
package key_pkg;

  localparam int unsigned CNT_W          = 26;
  localparam int unsigned LONG_CYC_DEF   = 50_000_000;
  localparam int unsigned DCLICK_CYC_DEF = 15_000_000;
  localparam int unsigned REPEAT_CYC_DEF = 10_000_000;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_PRESSED   = 5'b00010,
    ST_LONG_HELD = 5'b00100,
    ST_WAIT_2ND  = 5'b01000,
    ST_PRESSED2  = 5'b10000
  } key_fsm_e;

  // A cycle count must be at least 2 and still fit the counter.
  function automatic logic param_ok(input int unsigned cyc);
    return (cyc >= 2) && (cyc <= (32'd1 << CNT_W) - 32'd1);
  endfunction

  // Terminal value seen in the last cycle of an interval of 'cyc' cycles.
  function automatic cnt_t term_of(input int unsigned cyc);
    return cnt_t'(cyc - 32'd1);
  endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Key decoder bus: debounced key strobe/level in, gesture pulses and held level out.
interface key_event_decoder_if;

  logic key_flag;
  logic key_state;
  logic short_press;
  logic long_press;
  logic double_click;
  logic key_repeat;
  logic key_held;

  modport master (
    output key_flag, key_state,
    input  short_press, long_press, double_click, key_repeat, key_held
  );

  modport slave (
    input  key_flag, key_state,
    output short_press, long_press, double_click, key_repeat, key_held
  );

endinterface

// File: rtl/key_timer.sv
// Saturating cycle counter with synchronous clear, count enable and a
// combinational terminal-compare against a caller-supplied limit.
module key_timer
  import key_pkg::*;
(
  input  logic sys_clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  cnt_t limit_i,
  output logic hit_o
);

  cnt_t cnt_q;

  always_ff @(posedge sys_clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced key strobes into short/long/double-click pulses and a held level.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a long press is held.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned DCLICK_CYC = DCLICK_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input logic           sys_clk,
  input logic           rst,
  key_event_decoder_if.slave key_bus
);

  if (!param_ok(LONG_CYC) || !param_ok(DCLICK_CYC) || !param_ok(REPEAT_CYC)) begin : g_param_check
    $error("key_event_decoder: cycle parameters must lie in 2..2^26-1");
  end

  localparam cnt_t LONG_TERM   = term_of(LONG_CYC);
  localparam cnt_t DCLICK_TERM = term_of(DCLICK_CYC);

  key_fsm_e state_q, state_d;
  logic     short_q, short_d;
  logic     long_q, long_d;
  logic     dclick_q, dclick_d;
  logic     held_q, held_d;
  logic     tmr_clr, tmr_en, tmr_hit;
  cnt_t     tmr_lim;
  logic     press_ev, release_ev;

  assign press_ev   = key_bus.key_flag & ~key_bus.key_state;
  assign release_ev = key_bus.key_flag &  key_bus.key_state;

`ifdef KEY_REPEAT_EN
  localparam cnt_t REPEAT_TERM = term_of(REPEAT_CYC);
  logic rpt_q, rpt_d, rpt_tick;
`endif

  key_timer u_timer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_lim),
    .hit_o   (tmr_hit)
  );

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    dclick_d = 1'b0;
    tmr_en   = 1'b0;
    tmr_lim  = LONG_TERM;
`ifdef KEY_REPEAT_EN
    rpt_d    = 1'b0;
    rpt_tick = 1'b0;
`endif
    // Key-flag events are tested before timeouts so they win a same-cycle tie.
    case (state_q)
      ST_IDLE: begin
        if (press_ev) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        tmr_en  = 1'b1;
        tmr_lim = LONG_TERM;
        if (release_ev) begin
          state_d = ST_WAIT_2ND;
        end else if (tmr_hit) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
`ifdef KEY_REPEAT_EN
        tmr_en  = 1'b1;
        tmr_lim = REPEAT_TERM;
        if (release_ev) begin
          state_d = ST_IDLE;
        end else if (tmr_hit) begin
          rpt_d    = 1'b1;
          rpt_tick = 1'b1;
        end
`else
        if (release_ev) state_d = ST_IDLE;
`endif
      end
      ST_WAIT_2ND: begin
        tmr_en  = 1'b1;
        tmr_lim = DCLICK_TERM;
        if (press_ev) begin
          dclick_d = 1'b1;
          state_d  = ST_PRESSED2;
        end else if (tmr_hit) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED2: begin
        if (release_ev) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef KEY_REPEAT_EN
    tmr_clr = (state_d != state_q) | rpt_tick;
`else
    tmr_clr = (state_d != state_q);
`endif
    held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD) || (state_d == ST_PRESSED2);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dclick_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      long_q   <= long_d;
      dclick_q <= dclick_d;
      held_q   <= held_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rpt_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
  assign key_bus.key_repeat = rpt_q;
`else
  assign key_bus.key_repeat = 1'b0;
`endif

  assign key_bus.short_press  = short_q;
  assign key_bus.long_press   = long_q;
  assign key_bus.double_click = dclick_q;
  assign key_bus.key_held     = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed gesture table plus hand-written reset/held-level sequences for key_event_decoder.
module tb_key_event_decoder;

  localparam int LONG = 100;
  localparam int DCL  = 30;
  localparam int RPT  = 20;

`ifdef KEY_REPEAT_EN
  localparam int REP_N = 2;
  localparam int REP_T = 120;
`else
  localparam int REP_N = 0;
  localparam int REP_T = -1;
`endif

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  key_event_decoder_if kbus();

  key_event_decoder #(
    .LONG_CYC   (LONG),
    .DCLICK_CYC (DCL),
    .REPEAT_CYC (RPT)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .key_bus (kbus)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor; index 0 short, 1 long, 2 double click, 3 repeat.
  int   mon_cnt[4]   = '{0, 0, 0, 0};
  int   mon_first[4] = '{-1, -1, -1, -1};
  int   multi_hi     = 0;
  logic mon_clr      = 1'b0;
  logic [3:0] pulses;

  always @(negedge sys_clk) begin
    pulses = {kbus.key_repeat, kbus.double_click, kbus.long_press, kbus.short_press};
    if (mon_clr) begin
      for (int i = 0; i < 4; i++) begin
        mon_cnt[i]   = 0;
        mon_first[i] = -1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pulses[i]) begin
          if (mon_first[i] < 0) mon_first[i] = cyc;
          mon_cnt[i] = mon_cnt[i] + 1;
        end
      end
      if ($countones(pulses) > 1) multi_hi = multi_hi + 1;
    end
  end

  typedef struct {
    int hold;
    int gap;
    int hold2;
    int ns, ts;
    int nl, tl;
    int nd, td;
    int nr, tr;
  } vec_t;

  function automatic vec_t mk(input int hold, input int gap, input int hold2,
                              input int ns, input int ts, input int nl, input int tl,
                              input int nd, input int td, input int nr, input int tr);
    vec_t v;
    v.hold = hold; v.gap = gap; v.hold2 = hold2;
    v.ns = ns; v.ts = ts; v.nl = nl; v.tl = tl;
    v.nd = nd; v.td = td; v.nr = nr; v.tr = tr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic st);
    kbus.key_flag  = 1'b1;
    kbus.key_state = st;
    @(negedge sys_clk);
    kbus.key_flag  = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic clear_mon();
    @(posedge sys_clk);
    mon_clr = 1'b1;
    @(posedge sys_clk);
    mon_clr = 1'b0;
    @(negedge sys_clk);
  endtask

  // Called at a negedge; r is the first cycle the FSM spends in PRESSED.
  task automatic press(output int r);
    r = cyc + 1;
    strobe(1'b0);
  endtask

  int total_pulses;
  task automatic sum_pulses();
    total_pulses = mon_cnt[0] + mon_cnt[1] + mon_cnt[2] + mon_cnt[3];
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int r, r2;
    int en[4], et[4], rel;
    en = '{v.ns, v.nl, v.nd, v.nr};
    et = '{v.ts, v.tl, v.td, v.tr};
    clear_mon();
    press(r);
    wait_until(r + v.hold);
    strobe(1'b1);
    if (v.gap > 0) begin
      wait_until(r + v.hold + v.gap);
      press(r2);
      wait_until(r2 + v.hold2);
      strobe(1'b1);
    end
    repeat (70) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rel = (mon_first[i] < 0) ? -1 : (mon_first[i] - r);
      check($sformatf("vec%0d pulse%0d count", idx, i), mon_cnt[i], en[i]);
      check($sformatf("vec%0d pulse%0d cycle", idx, i), rel, et[i]);
    end
    check($sformatf("vec%0d key_held idle", idx), int'(kbus.key_held), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int r;
    // hold, gap, hold2, short n/t, long n/t, dclick n/t, repeat n/t (t relative to press)
    tbl[0] = mk(40,  0,  0, 1, 71,  0, -1,  0, -1, 0, -1);
    tbl[1] = mk(40, 10, 20, 0, -1,  0, -1,  1, 51, 0, -1);
    tbl[2] = mk(150, 0,  0, 0, -1,  1, 100, 0, -1, REP_N, REP_T);
    tbl[3] = mk(99,  0,  0, 1, 130, 0, -1,  0, -1, 0, -1);
    tbl[4] = mk(100, 0,  0, 0, -1,  1, 100, 0, -1, 0, -1);
    tbl[5] = mk(10, 30,  5, 0, -1,  0, -1,  1, 41, 0, -1);
    tbl[6] = mk(10, 31,  5, 2, 41,  0, -1,  0, -1, 0, -1);

    kbus.key_flag  = 1'b0;
    kbus.key_state = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset pulses", int'({kbus.short_press, kbus.long_press, kbus.double_click, kbus.key_repeat}), 0);
    check("reset key_held", int'(kbus.key_held), 0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Release strobe while idle must be ignored.
    clear_mon();
    strobe(1'b1);
    repeat (50) @(negedge sys_clk);
    sum_pulses();
    check("idle release pulses", total_pulses, 0);
    check("idle release key_held", int'(kbus.key_held), 0);

    // key_held level through PRESSED, WAIT_2ND, LONG_HELD.
    clear_mon();
    press(r);
    wait_until(r + 5);
    check("held in PRESSED", int'(kbus.key_held), 1);
    wait_until(r + 10);
    strobe(1'b1);
    wait_until(r + 13);
    check("held in WAIT_2ND", int'(kbus.key_held), 0);
    repeat (40) @(negedge sys_clk);
    press(r);
    wait_until(r + 110);
    check("held in LONG_HELD", int'(kbus.key_held), 1);
    strobe(1'b1);
    @(negedge sys_clk);
    check("held after long release", int'(kbus.key_held), 0);
    repeat (10) @(negedge sys_clk);

    // Reset mid-press discards the gesture.
    clear_mon();
    press(r);
    wait_until(r + 50);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("midreset pulses", int'({kbus.short_press, kbus.long_press, kbus.double_click, kbus.key_repeat}), 0);
    check("midreset key_held", int'(kbus.key_held), 0);
    wait_until(r + 60);
    strobe(1'b1);
    repeat (150) @(negedge sys_clk);
    sum_pulses();
    check("midreset later pulses", total_pulses, 0);
    run_vec(tbl[0], 7);

    check("one pulse per cycle", multi_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
